// File: rtl/moore_step_driver.sv
// Stimulus/observe driver for a stepped Moore FSM: replays a host-loaded queue of
// switch values one step at a time and returns the captured {state,out} per step.
module moore_step_driver #(
  parameter int SW_W  = 2,
  parameter int ST_W  = 3,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [SW_W-1:0] ld_sw,
  input  logic            start,
  input  logic [ST_W-1:0] init_state,
  output logic            dut_reset,
  output logic [ST_W-1:0] dut_state_in,
  output logic [SW_W-1:0] dut_sw,
  output logic            dut_ctrl,
  input  logic [ST_W-1:0] dut_state,
  input  logic            dut_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ST_W-1:0] rsp_state,
  output logic            rsp_out,
  output logic [7:0]      rsp_idx,
  output logic            busy,
  output logic            done,
  output logic [2:0]      dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] Q_FULL = (AW+1)'(DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] APPLY   = 3'd2;
  localparam logic [2:0] STEP    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] WAIT    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]      state;
  logic [SW_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;
  logic            q_empty;

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the producer holds its payload stable until that edge.
  assign q_empty  = (count == '0);
  assign ld_ready = (count != Q_FULL);
  assign push     = ld_valid & ld_ready;
  assign pop      = (state == STEP) & !q_empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ld_sw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dut_state_in <= '0;
      dut_sw       <= '0;
      rsp_valid    <= 1'b0;
      rsp_state    <= '0;
      rsp_out      <= 1'b0;
      rsp_idx      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dut_state_in <= init_state;
            rsp_idx      <= 8'd0;
            state        <= INIT;
          end
        end
        INIT:  state <= q_empty ? DONE : APPLY;
        APPLY: begin
          // Loaded here so the FSM's next-state logic sees it a full cycle before the step.
          dut_sw <= mem[rd_ptr];
          state  <= STEP;
        end
        STEP:  state <= CAPTURE;
        CAPTURE: begin
          rsp_state <= dut_state;
          rsp_out   <= dut_out;
          rsp_valid <= 1'b1;
          state     <= WAIT;
        end
        WAIT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_idx   <= rsp_idx + 8'd1;
            state     <= q_empty ? DONE : APPLY;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are masked by reset so an abort never steps the FSM or signals completion.
  assign dut_reset = reset | (state == INIT);
  assign dut_ctrl  = (state == STEP) & !reset;
  assign done      = (state == DONE) & !reset;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_moore_step_driver.sv
// Directed bench for moore_step_driver driving a small 2-state Moore FSM model,
// with immediate assertions at every comparison point.
module tb_moore_step_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_sw;
  logic       start;
  logic [2:0] init_state;
  logic       dut_reset;
  logic [2:0] dut_state_in;
  logic [1:0] dut_sw;
  logic       dut_ctrl;
  logic [2:0] dut_state;
  logic       dut_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_state;
  logic       rsp_out;
  logic [7:0] rsp_idx;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  int ctrl_pulses = 0;
  int overlap     = 0;

  always #5 clk = ~clk;

  moore_step_driver #(.SW_W(2), .ST_W(3), .DEPTH(16)) u_dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sw(ld_sw),
    .start(start), .init_state(init_state),
    .dut_reset(dut_reset), .dut_state_in(dut_state_in), .dut_sw(dut_sw), .dut_ctrl(dut_ctrl),
    .dut_state(dut_state), .dut_out(dut_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state), .rsp_out(rsp_out),
    .rsp_idx(rsp_idx), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Reference transition of the 2-state test FSM: returns {next_state, out}.
  function automatic logic [3:0] ref_step(input logic [2:0] s, input logic [1:0] sw);
    if (s == 3'd0) return (sw != 2'd0) ? {3'd1, 1'b1} : {3'd0, 1'b0};
    else           return (sw == 2'd0 || sw == 2'd2) ? {3'd1, 1'b1} : {3'd0, 1'b0};
  endfunction

  // The FSM under stimulus: load on reset strobe, advance only on step enable.
  always_ff @(posedge clk) begin
    if (dut_reset) begin
      dut_state <= dut_state_in;
      dut_out   <= 1'b0;
    end else if (dut_ctrl) begin
      {dut_state, dut_out} <= ref_step(dut_state, dut_sw);
    end
  end

  always @(negedge clk) begin
    if (dut_ctrl) ctrl_pulses++;
    if (dut_ctrl && dut_reset) overlap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] v);
    ld_valid = 1'b1;
    ld_sw    = v;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] s);
    init_state = s;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_rsp(input int idx, input logic [2:0] st, input logic o);
    for (int k = 0; k < 20 && !rsp_valid; k++) tick();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_idx", rsp_idx, idx);
    check("rsp_state", rsp_state, st);
    check("rsp_out", rsp_out, o);
    tick();
  endtask

  task automatic wait_done;
    for (int k = 0; k < 20 && !done; k++) tick();
    check("done_pulse", done, 1);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    logic [1:0] sw_tab [16];
    logic [3:0] r;
    logic [2:0] es;
    int c0;

    reset = 1'b1; ld_valid = 1'b0; ld_sw = 2'd0; start = 1'b0;
    init_state = 3'd0; rsp_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_done", done, 0);
    check("rst_ctrl", dut_ctrl, 0);
    check("rst_dut_reset", dut_reset, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_rsp_idx", rsp_idx, 0);
    check("rst_dut_sw", dut_sw, 0);
    check("rst_state_in", dut_state_in, 0);
    reset = 1'b0;
    tick();
    check("idle_dut_reset", dut_reset, 0);

    // Main sequence: sw 1,0,2,3 from state 0.
    push(2'd1); push(2'd0); push(2'd2); push(2'd3);
    c0 = ctrl_pulses;
    pulse_start(3'd0);
    check("t1_init_reset", dut_reset, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_apply_reset", dut_reset, 0);
    check("t1_apply_ctrl", dut_ctrl, 0);
    tick();
    check("t1_first_ctrl", dut_ctrl, 1);
    check("t1_first_sw", dut_sw, 1);
    wait_rsp(0, 3'd1, 1'b1);
    wait_rsp(1, 3'd1, 1'b1);
    wait_rsp(2, 3'd1, 1'b1);
    wait_rsp(3, 3'd0, 1'b0);
    wait_done();
    check("t1_ctrl_count", ctrl_pulses - c0, 4);
    check("t1_sw_hold", dut_sw, 3);

    // Empty queue: reset strobe then done, no step.
    c0 = ctrl_pulses;
    pulse_start(3'd0);
    check("t2_init_reset", dut_reset, 1);
    tick();
    check("t2_done", done, 1);
    check("t2_no_rsp", rsp_valid, 0);
    tick();
    check("t2_idle", busy, 0);
    check("t2_no_ctrl", ctrl_pulses - c0, 0);

    // Fill the queue, offer one extra word, then replay all entries.
    for (int i = 0; i < 16; i++) begin
      sw_tab[i] = 2'(i ^ (i >> 2));
      push(sw_tab[i]);
      if (i == 14) check("t3_ready_before_full", ld_ready, 1);
    end
    check("t3_full", ld_ready, 0);
    ld_valid = 1'b1; ld_sw = 2'd3;
    tick();
    ld_valid = 1'b0;
    check("t3_still_full", ld_ready, 0);
    c0 = ctrl_pulses;
    pulse_start(3'd0);
    es = 3'd0;
    for (int i = 0; i < 16; i++) begin
      r = ref_step(es, sw_tab[i]);
      wait_rsp(i, r[3:1], r[0]);
      es = r[3:1];
    end
    wait_done();
    check("t3_ctrl_count", ctrl_pulses - c0, 16);

    // Backpressure on step 1.
    push(2'd1); push(2'd0); push(2'd2);
    pulse_start(3'd0);
    wait_rsp(0, 3'd1, 1'b1);
    rsp_ready = 1'b0;
    wait_rsp(1, 3'd1, 1'b1);
    c0 = ctrl_pulses;
    for (int k = 0; k < 4; k++) begin
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_idx", rsp_idx, 1);
      check("t4_hold_state", rsp_state, 1);
      check("t4_hold_out", rsp_out, 1);
      tick();
    end
    check("t4_no_ctrl_while_held", ctrl_pulses - c0, 0);
    rsp_ready = 1'b1;
    tick();
    wait_rsp(2, 3'd1, 1'b1);
    wait_done();

    // Abort during the step of step 2.
    push(2'd1); push(2'd0); push(2'd2); push(2'd3);
    pulse_start(3'd0);
    wait_rsp(0, 3'd1, 1'b1);
    wait_rsp(1, 3'd1, 1'b1);
    tick();
    check("t5_in_step", dut_ctrl, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_rsp_idx", rsp_idx, 0);
    check("t5_ld_ready", ld_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check("t5_no_done", done, 0);
      tick();
    end
    c0 = ctrl_pulses;
    pulse_start(3'd0);
    tick();
    check("t5_queue_empty_done", done, 1);
    tick();
    check("t5_no_ctrl", ctrl_pulses - c0, 0);

    // Non-zero initial state.
    push(2'd1);
    pulse_start(3'd1);
    check("t6_state_in", dut_state_in, 1);
    tick();
    check("t6_loaded", dut_state, 1);
    wait_rsp(0, 3'd0, 1'b0);
    wait_done();
    check("ctrl_reset_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
